// File: rtl/cs_pkg.sv
// cs_pkg: shared sizing helpers and mode encodings for the cs_window_appr block.
//   sum_w(W,N)       : width of the running window sum.
//   y_w(W,N,SHIFT)   : width of the result port Y.
//   CS_MODE_APPR/AVG : values of the per-sample mode bit.
package cs_pkg;

   function automatic int sum_w(input int w, input int n);
      return w + $clog2(n);
   endfunction

   function automatic int y_w(input int w, input int n, input int shift);
      return w + $clog2(n) + 1 - shift;
   endfunction

   localparam logic CS_MODE_APPR = 1'b0;
   localparam logic CS_MODE_AVG  = 1'b1;

endpackage

// File: rtl/cs_window_appr_if.sv
// cs_window_appr_if: sample/result handshake bundle.
//   in_valid, mode, X : sample side, driven by the source (master).
//   Y, out_valid      : result side, driven by the block (slave).
interface cs_window_appr_if #(
   parameter int W  = 8,
   parameter int YW = 10
);
   logic          in_valid;
   logic          mode;
   logic [W-1:0]  X;
   logic [YW-1:0] Y;
   logic          out_valid;

   modport master (output in_valid, output mode, output X, input Y, input out_valid);
   modport slave  (input in_valid, input mode, input X, output Y, output out_valid);
endinterface

// File: rtl/cs_appr_tree.sv
// cs_appr_tree: combinational "<= threshold, then max" reduction over the window.
//   win_flat : N samples of W bits, sample i at bits [i*W +: W].
//   avg      : threshold (floor of the window mean).
//   x_appr   : largest sample not exceeding avg; 0 if none qualify.
module cs_appr_tree #(
   parameter int W = 8,
   parameter int N = 9
) (
   input  logic [N*W-1:0] win_flat,
   input  logic [W-1:0]   avg,
   output logic [W-1:0]   x_appr
);
   // Leaf count rounded up to a power of two so the tree is balanced.
   localparam int P = 1 << $clog2(N);

   logic [W-1:0] leaf [P];
   logic [W-1:0] node [P];

   // A sample above the threshold is replaced by 0 so it can never win the max.
   // Padding leaves are also 0.
   generate
      for (genvar gi = 0; gi < P; gi++) begin : g_leaf
         if (gi < N) begin : g_used
            logic [W-1:0] sample;
            assign sample   = win_flat[gi*W +: W];
            assign leaf[gi] = (sample <= avg) ? sample : '0;
         end else begin : g_pad
            assign leaf[gi] = '0;
         end
      end
   endgenerate

   // In-place pairwise max, halving the live width each level. Slot i is only
   // overwritten after slots 2i and 2i+1 have been consumed.
   always_comb begin
      for (int i = 0; i < P; i++) node[i] = leaf[i];
      for (int s = P / 2; s >= 1; s = s / 2) begin
         for (int i = 0; i < s; i++) begin
            node[i] = (node[2*i] > node[2*i+1]) ? node[2*i] : node[2*i+1];
         end
      end
   end

   assign x_appr = node[0];

endmodule

// File: rtl/cs_window_appr.sv
// cs_window_appr: sliding-window CS approximation / average engine.
//   clk   : clock, all state on the rising edge.
//   reset : synchronous active-high clear, dominates all other inputs.
//   bus   : slave side of cs_window_appr_if.
//           in_valid/mode/X accept a sample.
//           Y/out_valid return the result two cycles after X is presented.
// Stage 1 holds the window, running sum and fill count. Stage 2 reads those
// registers and produces a registered Y.
module cs_window_appr
   import cs_pkg::*;
#(
   parameter int W         = 8,
   parameter int N         = 9,
   parameter int SHIFT     = 3,
   parameter int EARLY_OUT = 0
) (
   input  logic           clk,
   input  logic           reset,
   cs_window_appr_if.slave bus
);
   localparam int SW = sum_w(W, N);
   localparam int YW = y_w(W, N, SHIFT);
   localparam int PW = W + $clog2(N) + 1;
   localparam int FW = $clog2(N + 1);

   // Stage-1 state
   logic [W-1:0]  win_reg [N];
   logic [SW-1:0] sum_reg;
   logic [FW-1:0] fill_reg;
   logic          mode2_reg;
   logic          v2_reg;

   // Output registers
   logic [YW-1:0] y_reg;
   logic          out_valid_reg;

   logic [SW-1:0] sum_next;
   logic [FW-1:0] fill_next;
   logic          full_next;

   // Drop the oldest sample before adding the new one. The extra bit keeps the
   // intermediate difference from wrapping.
   assign sum_next  = SW'((SW+1)'(sum_reg) - (SW+1)'(win_reg[N-1]) + (SW+1)'(bus.X));
   assign fill_next = (fill_reg == FW'(N)) ? fill_reg : fill_reg + FW'(1);
   assign full_next = (fill_next == FW'(N));

   // Stage 2: the average, the approximation and the result.
   logic [W-1:0]   avg;
   logic [W-1:0]   x_appr;
   logic [N*W-1:0] win_flat;
   logic [PW-1:0]  appr_total;
   logic [YW-1:0]  y_next;

   assign avg = W'(sum_reg / SW'(N));

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_flat
         assign win_flat[gi*W +: W] = win_reg[gi];
      end
   endgenerate

   cs_appr_tree #(
      .W (W),
      .N (N)
   ) u_tree (
      .win_flat (win_flat),
      .avg      (avg),
      .x_appr   (x_appr)
   );

   assign appr_total = PW'(N) * PW'(x_appr) + PW'(sum_reg);
   assign y_next     = (mode2_reg == CS_MODE_AVG) ? YW'(avg) : YW'(appr_total >> SHIFT);

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < N; i++) win_reg[i] <= '0;
         sum_reg       <= '0;
         fill_reg      <= '0;
         mode2_reg     <= 1'b0;
         v2_reg        <= 1'b0;
         y_reg         <= '0;
         out_valid_reg <= 1'b0;
      end else begin
         out_valid_reg <= v2_reg;
         // Y only moves when a result is produced, so it holds across gaps.
         if (v2_reg) y_reg <= y_next;
         v2_reg <= bus.in_valid && ((EARLY_OUT != 0) || full_next);
         if (bus.in_valid) begin
            for (int i = N - 1; i > 0; i--) win_reg[i] <= win_reg[i-1];
            win_reg[0] <= bus.X;
            sum_reg    <= sum_next;
            fill_reg   <= fill_next;
            mode2_reg  <= bus.mode;
         end
      end
   end

   assign bus.Y         = y_reg;
   assign bus.out_valid = out_valid_reg;

endmodule

// File: tb/tb_cs_window_appr.sv
// tb_cs_window_appr: drives identical stimulus into an EARLY_OUT=0 and an
// EARLY_OUT=1 instance. A reference model fills expected-result queues. A
// separate monitor pops the queues and checks value and arrival cycle.
module tb_cs_window_appr;
   import cs_pkg::*;

   localparam int W     = 8;
   localparam int N     = 9;
   localparam int SHIFT = 3;
   localparam int YW    = y_w(W, N, SHIFT);

   typedef struct {
      int unsigned y;
      int unsigned cyc;
   } exp_t;

   logic         clk;
   logic         reset;
   logic         in_valid;
   logic         mode;
   logic [W-1:0] X;

   cs_window_appr_if #(.W(W), .YW(YW)) bus0 ();
   cs_window_appr_if #(.W(W), .YW(YW)) bus1 ();

   assign bus0.in_valid = in_valid;
   assign bus0.mode     = mode;
   assign bus0.X        = X;
   assign bus1.in_valid = in_valid;
   assign bus1.mode     = mode;
   assign bus1.X        = X;

   cs_window_appr #(.W(W), .N(N), .SHIFT(SHIFT), .EARLY_OUT(0)) dut0 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus0)
   );

   cs_window_appr #(.W(W), .N(N), .SHIFT(SHIFT), .EARLY_OUT(1)) dut1 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus1)
   );

   int          checks   = 0;
   int          failures = 0;
   int unsigned cyc      = 0;

   exp_t        q0[$];
   exp_t        q1[$];
   int unsigned mwin[N];
   int          mfill;
   int unsigned last_y[2];
   int unsigned obs_y[2];
   int          nv[2];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- reference model ----------------
   task automatic clear_model();
      for (int i = 0; i < N; i++) mwin[i] = 0;
      mfill = 0;
      q0.delete();
      q1.delete();
   endtask

   task automatic model_accept(input int unsigned x, input logic m);
      int unsigned sum;
      int unsigned av;
      int unsigned xa;
      int unsigned y;
      exp_t        e;
      for (int i = N - 1; i > 0; i--) mwin[i] = mwin[i-1];
      mwin[0] = x;
      if (mfill < N) mfill++;
      sum = 0;
      for (int i = 0; i < N; i++) sum += mwin[i];
      av = sum / N;
      xa = 0;
      for (int i = 0; i < N; i++) if (mwin[i] <= av && mwin[i] > xa) xa = mwin[i];
      if (m == CS_MODE_AVG) y = av;
      else y = (N * xa + sum) >> SHIFT;
      y     = y % (1 << YW);
      e.y   = y;
      e.cyc = cyc + 2;
      if (mfill == N) q0.push_back(e);
      q1.push_back(e);
   endtask

   // ---------------- monitor ----------------
   task automatic check_dut(input int i, input logic v, input logic [YW-1:0] y);
      exp_t e;
      if (reset) begin
         checks++;
         if (v !== 1'b0 || y !== '0) begin
            failures++;
            $display("FAIL reset_state dut%0d: out_valid=%b Y=%0d, required 0/0", i, v, y);
         end
         last_y[i] = 0;
      end else if (v === 1'b1) begin
         checks++;
         nv[i]++;
         obs_y[i] = y;
         if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
            failures++;
            $display("FAIL unexpected_out dut%0d: Y=%0d at cyc %0d, no result pending", i, y, cyc);
         end else begin
            if (i == 0) e = q0.pop_front();
            else e = q1.pop_front();
            $display("dut%0d cyc=%0d Y=%0d expected Y=%0d at cyc=%0d", i, cyc, y, e.y, e.cyc);
            if (y !== YW'(e.y) || cyc != e.cyc) begin
               failures++;
               $display("FAIL result dut%0d: Y=%0d cyc=%0d, required Y=%0d cyc=%0d",
                        i, y, cyc, e.y, e.cyc);
            end
            last_y[i] = e.y;
         end
      end else begin
         checks++;
         if (v !== 1'b0 || y !== YW'(last_y[i])) begin
            failures++;
            $display("FAIL hold dut%0d: out_valid=%b Y=%0d, required 0/%0d", i, v, y, last_y[i]);
         end
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         check_dut(0, bus0.out_valid, bus0.Y);
         check_dut(1, bus1.out_valid, bus1.Y);
      end
   end

   // ---------------- stimulus ----------------
   task automatic drive(input logic v, input int unsigned x, input logic m);
      @(negedge clk);
      in_valid = v;
      X        = W'(x);
      mode     = m;
      if (v) model_accept(x, m);
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, $urandom_range(255), 1'b0);
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      reset    = 1'b1;
      in_valid = 1'b0;
      clear_model();
      repeat (n) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic expect_val(input string name, input int got, input int req);
      checks++;
      if (got != req) begin
         failures++;
         $display("FAIL %s: got %0d, required %0d", name, got, req);
      end
   endtask

   initial begin
      int n0;
      int n1;
      reset    = 1'b1;
      in_valid = 1'b0;
      mode     = 1'b0;
      X        = '0;
      last_y   = '{0, 0};
      obs_y    = '{0, 0};
      nv       = '{0, 0};
      clear_model();
      repeat (3) @(negedge clk);
      reset = 1'b0;

      // 1..9: a single full-window result
      n0 = nv[0];
      for (int k = 1; k <= 9; k++) drive(1'b1, k, CS_MODE_APPR);
      idle(3);
      expect_val("fill_y", obs_y[0], 11);
      expect_val("fill_count", nv[0] - n0, 1);

      // slide by one
      drive(1'b1, 10, CS_MODE_APPR);
      idle(3);
      expect_val("slide_y", obs_y[0], 13);

      // full-scale window
      repeat (9) drive(1'b1, 255, CS_MODE_APPR);
      idle(3);
      expect_val("max_y", obs_y[0], 573);

      // zero-filled window on the early-output instance
      do_reset(2);
      n0 = nv[0];
      n1 = nv[1];
      drive(1'b1, 90, CS_MODE_APPR);
      idle(3);
      expect_val("early_y", obs_y[1], 11);
      expect_val("early_count", nv[1] - n1, 1);
      expect_val("late_count", nv[0] - n0, 0);

      // average mode, then per-sample mode alternation
      do_reset(2);
      for (int k = 1; k <= 9; k++) drive(1'b1, k, CS_MODE_AVG);
      idle(3);
      expect_val("avg_y", obs_y[0], 5);
      drive(1'b1, 10, CS_MODE_APPR);
      drive(1'b1, 11, CS_MODE_AVG);
      drive(1'b1, 12, CS_MODE_APPR);
      idle(3);
      expect_val("alt_y", obs_y[0], 18);

      // handshake gaps
      do_reset(2);
      n0 = nv[0];
      for (int k = 1; k <= 9; k++) begin
         drive(1'b1, k, CS_MODE_APPR);
         repeat (k % 3) drive(1'b0, $urandom_range(255), 1'b1);
      end
      idle(3);
      expect_val("gap_y", obs_y[0], 11);
      expect_val("gap_count", nv[0] - n0, 1);

      // reset mid-stream, then refill
      do_reset(2);
      for (int k = 1; k <= 5; k++) drive(1'b1, 30 + k, CS_MODE_APPR);
      do_reset(1);
      n0 = nv[0];
      repeat (9) drive(1'b1, 20, CS_MODE_APPR);
      idle(3);
      expect_val("refill_y", obs_y[0], 45);
      expect_val("refill_count", nv[0] - n0, 1);

      // randomized traffic, occasional reset (sometimes together with in_valid)
      for (int c = 0; c < 500; c++) begin
         @(negedge clk);
         if ($urandom_range(99) < 2) begin
            reset    = 1'b1;
            in_valid = 1'($urandom_range(1));
            X        = W'($urandom_range(255));
            clear_model();
         end else begin
            reset    = 1'b0;
            in_valid = ($urandom_range(99) < 75);
            X        = ($urandom_range(3) == 0) ? W'(255) : W'($urandom_range(255));
            mode     = 1'($urandom_range(1));
            if (in_valid) model_accept(X, mode);
         end
      end
      @(negedge clk);
      reset    = 1'b0;
      in_valid = 1'b0;
      idle(4);

      expect_val("pending_dut0", q0.size(), 0);
      expect_val("pending_dut1", q1.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
